// File: rtl/iterative_divider.sv
// iterative_divider
//   Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU). Uses a radix-2
//   restoring algorithm, one quotient bit per clock. Division by zero and
//   signed overflow skip the iterations and produce their fixed results.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset
//   start    in   1  begin an operation (sampled only in IDLE)
//   op       in   2  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend in  32  rs1, sampled with start
//   divisor  in  32  rs2, sampled with start
//   busy     out  1  high in CALC, FINISH and DONE
//   done     out  1  one-cycle pulse, result_d valid
//   result_d out 32  quotient or remainder, held until the next result

module iterative_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [4:0]  r_cnt;
  logic        r_sel_rem;   // op[1]: return remainder instead of quotient
  logic        r_special;   // results preloaded, no sign correction
  logic        r_q_neg;
  logic        r_r_neg;
  logic [31:0] r_dvsr;      // divisor magnitude
  logic [31:0] r_quo;       // dividend magnitude shifting out, quotient in
  logic [31:0] r_rem;
  logic [31:0] r_result;

  logic        w_signed;
  logic        w_div_zero;
  logic        w_overflow;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift_rem;
  logic [33:0] w_diff;
  logic        w_take;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_signed   = ~op[0];
  assign w_div_zero = (divisor == 32'd0);
  assign w_overflow = w_signed && (dividend == 32'h8000_0000) &&
                      (divisor == 32'hFFFF_FFFF);
  assign w_a_mag    = (w_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign w_b_mag    = (w_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // One restoring step: the partial remainder gains the next dividend bit;
  // bit 33 of the difference is the borrow, i.e. the trial went negative.
  assign w_shift_rem = {r_rem, r_quo[31]};
  assign w_diff      = {1'b0, w_shift_rem} - {2'b00, r_dvsr};
  assign w_take      = ~w_diff[33];

  assign w_q_fix = (r_q_neg && !r_special) ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix = (r_r_neg && !r_special) ? (~r_rem + 32'd1) : r_rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and status outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = (w_div_zero || w_overflow) ? FINISH : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == 5'd31) w_state_next = FINISH;
      end
      FINISH: begin
        busy         = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_sel_rem <= 1'b0;
      r_special <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dvsr    <= 32'd0;
      r_quo     <= 32'd0;
      r_rem     <= 32'd0;
      r_result  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt     <= 5'd0;
            r_sel_rem <= op[1];
            r_q_neg   <= w_signed && (dividend[31] ^ divisor[31]);
            r_r_neg   <= w_signed && dividend[31];
            r_dvsr    <= w_b_mag;
            if (w_div_zero) begin
              r_special <= 1'b1;
              r_quo     <= 32'hFFFF_FFFF;
              r_rem     <= dividend;
            end else if (w_overflow) begin
              r_special <= 1'b1;
              r_quo     <= 32'h8000_0000;
              r_rem     <= 32'd0;
            end else begin
              r_special <= 1'b0;
              r_quo     <= w_a_mag;
              r_rem     <= 32'd0;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 5'd1;   // wraps 31 -> 0 on the last step
          r_quo <= {r_quo[30:0], w_take};
          // In the restore case the shifted remainder is below the divisor,
          // so it always fits in 32 bits.
          r_rem <= w_take ? w_diff[31:0] : w_shift_rem[31:0];
        end
        FINISH: begin
          r_result <= r_sel_rem ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign result_d = r_result;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iterative_divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result_d (result_d)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a start at the current point (just after an edge) and waits for
  // done. Latency counts edges, the accepting edge being edge 1.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int cyc, output logic [31:0] res);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); cyc = 1; #1;
    start = 1'b0;
    check({name, " busy after accept"}, 32'(busy), 32'd1);
    while (!done && cyc < 100) begin
      @(posedge clk); cyc++; #1;
    end
    res = result_d;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s: timeout, done never rose", name);
    end
    @(posedge clk); #1;
    check({name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[14];
  int          cyc;
  logic [31:0] res;
  logic        saw_done;

  initial begin
    vecs[0]  = '{"DIVU 100/7",      OP_DIVU, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{"REMU 100/7",      OP_REMU, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{"DIV -7/2",        OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{"REM -7/2",        OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{"DIV 5/0",         OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vecs[5]  = '{"REMU 5/0",        OP_REMU, 32'd5,          32'd0,          32'd5,          2};
    vecs[6]  = '{"DIV ovf",         OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
    vecs[7]  = '{"REM ovf",         OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
    vecs[8]  = '{"DIV 7/-2",        OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
    vecs[9]  = '{"REM 7/-2",        OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[10] = '{"DIVU max/1",      OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vecs[11] = '{"REM -5/0",        OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  2};
    vecs[12] = '{"DIVU 8000.../ff", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
    vecs[13] = '{"REMU 8000.../ff", OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};

    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",     32'(busy), 32'd0);
    check("reset done",     32'(done), 32'd0);
    check("reset result_d", result_d,  32'd0);
    rst = 1'b0;

    // First vector is started immediately, so it is accepted on the first
    // edge after reset release.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, cyc, res);
      check({vecs[i].name, " result"},  res,      vecs[i].exp);
      check({vecs[i].name, " latency"}, 32'(cyc), 32'(vecs[i].lat));
      $display("op %-16s a=%h b=%h result=%h latency=%0d", vecs[i].name,
               vecs[i].a, vecs[i].b, res, cyc);
    end

    // Start pulses during CALC must be ignored.
    op = OP_DIVU; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clk); cyc = 1; #1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      op = OP_REMU; dividend = 32'd77; divisor = 32'd5; start = ~start;
      @(posedge clk); cyc++; #1;
    end
    start = 1'b0;
    while (!done && cyc < 100) begin
      @(posedge clk); cyc++; #1;
    end
    check("busy-start result",  result_d, 32'd100);
    check("busy-start latency", 32'(cyc), 32'd34);
    $display("op busy-start DIVU 1000/10 result=%h latency=%0d", result_d, cyc);

    // Start held through the done cycle: ignored there, accepted next cycle.
    op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    check("start in done ignored", 32'(busy), 32'd0);
    @(posedge clk); cyc = 1; #1;
    start = 1'b0;
    check("start after done accepted", 32'(busy), 32'd1);
    check("result held during calc", result_d, 32'd100);
    while (!done && cyc < 100) begin
      @(posedge clk); cyc++; #1;
    end
    check("back-to-back result",  result_d, 32'd10);
    check("back-to-back latency", 32'(cyc), 32'd34);
    $display("op back-to-back DIVU 50/5 result=%h latency=%0d", result_d, cyc);
    @(posedge clk); #1;

    // Reset in the middle of CALC aborts with no done pulse.
    op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy",     32'(busy), 32'd0);
    check("abort done",     32'(done), 32'd0);
    check("abort result_d", result_d,  32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no done pulse", 32'(saw_done), 32'd0);
    $display("op reset-abort busy=%0d result=%h", busy, result_d);

    run_op("DIVU 9/3", OP_DIVU, 32'd9, 32'd3, cyc, res);
    check("post-abort result",  res,      32'd3);
    check("post-abort latency", 32'(cyc), 32'd34);
    $display("op DIVU 9/3 after abort result=%h latency=%0d", res, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: a synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: a request to begin a division, sampled only in IDLE.
REQ-004 The block SHALL have the port op, input, 2 bits: funct3[1:0] of the M-extension divide group, with 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 The block SHALL have the port dividend, input, 32 bits: rs1, sampled with start.
REQ-006 The block SHALL have the port divisor, input, 32 bits: rs2, sampled with start.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while an operation is in flight, not in IDLE.
REQ-008 The block SHALL have the port done, output, 1 bit: a one-cycle pulse indicating that result_d is valid.
REQ-009 The block SHALL have the port result_d, output, 32 bits: the quotient or remainder, held until the next accepted start.

Function
REQ-010 The block SHALL implement the states IDLE, CALC, FINISH and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch op, dividend and divisor on that edge; any start in another state SHALL be ignored.
REQ-012 On acceptance, if divisor==0 or (signed op, dividend==32'h8000_0000, divisor==32'hFFFF_FFFF), the block SHALL set a special flag and go to FINISH; otherwise it SHALL go to CALC with the 5-bit iteration counter cleared.
REQ-013 For signed ops the block SHALL take operand magnitudes on acceptance and record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend).
REQ-014 CALC SHALL perform one radix-2 restoring step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor magnitude from the 33-bit partial remainder, keep the difference and set the quotient LSB to 1 if the difference is non-negative, else restore and set the LSB to 0.
REQ-015 CALC SHALL last exactly 32 cycles, then the counter SHALL wrap from 31 to FINISH without re-entering CALC.
REQ-016 In FINISH the block SHALL apply sign correction by two's-complement negation, select the quotient (DIV/DIVU) or the remainder (REM/REMU), and load result_d.
REQ-017 Special-case results SHALL be: div-by-zero gives quotient 32'hFFFF_FFFF for both signed and unsigned and remainder = dividend; overflow gives quotient 32'h8000_0000 and remainder 0.
REQ-018 FINISH SHALL go to DONE, and DONE SHALL assert done=1 for exactly one cycle before returning to IDLE.
REQ-019 Latency from the start edge to done high SHALL be 34 cycles in the normal case and 2 cycles in the special case.
REQ-020 busy SHALL be high in CALC, FINISH and DONE.
REQ-021 A start in the cycle done is high SHALL be ignored; the earliest next accept SHALL be the following cycle (IDLE).
REQ-022 DIVU and REMU SHALL treat both operands as unsigned, with no sign correction.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL go to IDLE and set busy=0, done=0, result_d=0 and counter=0.
REQ-024 rst SHALL take priority over start and over any in-flight operation, aborting it with no done pulse.
REQ-025 After rst deasserts, the block SHALL accept start on the first edge.

Verification
REQ-026 A bench SHALL check DIVU 100/7, expecting done at 34 cycles and result_d=14; and REMU 100/7, expecting result_d=2.
REQ-027 A bench SHALL check DIV -7/2, expecting 32'hFFFF_FFFD; and REM -7/2, expecting 32'hFFFF_FFFF, where the remainder sign follows the dividend.
REQ-028 A bench SHALL check DIV 5/0, expecting 32'hFFFF_FFFF after 2 cycles; and REMU 5/0, expecting 5.
REQ-029 A bench SHALL check DIV 32'h8000_0000/32'hFFFF_FFFF, expecting 32'h8000_0000 after 2 cycles; and REM of the same operands, expecting 0.
REQ-030 A bench SHALL check that start pulsed repeatedly during CALC has no effect, that the result equals the first operation, and that a second start in the cycle after done is accepted.
REQ-031 A bench SHALL check that rst asserted at CALC iteration 10 gives busy=0 and result_d=0 the next cycle with no done pulse, and that a fresh DIVU 9/3 afterwards returns 3.
